id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

Parametrised decode-to-execute pipeline register with a valid/ready handshake, optional two-entry skid buffer, flush and global-enable control, and load-use hazard detection over every held entry. It sits between the decoder and the ALU and replaces fixed stall-vector bubble insertion with backpressure. The payload is opaque except for the destination-register and load fields, so one block serves any decoded-instruction format.

## Interface
Parameters:
- DATA_W, 128, width of the opaque decoded payload (reg1, reg2, imm, aluop, alusel, pc packed by the decoder)
- RA_W, 5, register-address width
- SKID, 1, 1 = two-entry skid buffer with fully registered in_ready; 0 = single entry with combinational in_ready

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; 0 freezes all state
- flush  in  1  branch/jump kill; discards all held and incoming entries
- in_valid  in  1  decoder has an entry
- in_ready  out  1  block accepts an entry this cycle
- in_data  in  DATA_W  payload
- in_rd  in  RA_W  destination register
- in_rd_en  in  1  entry writes rd
- in_is_load  in  1  entry is a load
- out_valid  out  1  head entry valid for EX
- out_ready  in  1  EX consumes head this cycle
- out_data  out  DATA_W  head payload
- out_rd  out  RA_W  head destination register
- out_rd_en  out  1  head writes rd
- chk_rs1, chk_rs2  in  RA_W  source registers of the instruction currently in ID
- chk_rs1_en, chk_rs2_en  in  1  source-register use enables
- load_use  out  1  ID instruction must hold: a held load targets one of its sources
- flush_cnt  out  16  number of flushes that discarded one or more valid entries

## Operation
- Storage: head entry H (valid, data, rd, rd_en, is_load); when SKID=1, also skid entry S with the same fields.
- Accept = in_valid & in_ready & rdy & ~flush. Pop = out_valid & out_ready.
- SKID=1, per edge (rdy=1, no flush):
  - H empty: accept goes to H.
  - H full, pop, S empty: accept (if any) goes to H.
  - H full, pop, S full: S moves to H, and S is cleared. in_ready was 0, so there is no accept.
  - H full, no pop: accept goes to S.
  - in_ready is a register equal to ~S.valid of the next state.
- SKID=0:
  - in_ready = rdy & (~H.valid | out_ready), combinational.
  - Accept loads H. Pop without accept clears H.valid.
- Order is strict FIFO; no entry is duplicated or lost except by flush.
- flush=1 with rdy=1:
  - H.valid and S.valid are cleared at the edge.
  - The incoming entry is dropped, and in_ready is set to 1 for the next cycle.
  - A pop in the same cycle still counts as consumed by EX.
  - flush_cnt increments (saturating at 0xFFFF) if H.valid or S.valid was 1 before the edge.
- rdy=0: no state changes, flush is ignored, in_ready and out_valid are driven 0 combinationally, and data outputs hold.
- Outputs: out_valid = H.valid & rdy; out_data, out_rd and out_rd_en come from H.
- Hazard:
  - match(E) = E.valid & E.is_load & E.rd_en & E.rd≠0 & ((chk_rs1_en & chk_rs1=E.rd) | (chk_rs2_en & chk_rs2=E.rd)).
  - load_use = match(H) | match(S), combinational from registers and chk inputs only.
  - load_use is independent of rdy and flush.
- Payload contents are never interpreted; invalid entries keep stale data.

## Timing
- Reset, at the first edge with rst=1 (overrides rdy and flush):
  - H.valid and S.valid = 0.
  - All payload, rd, rd_en and is_load fields = 0.
  - flush_cnt = 0.
  - in_ready = 1 (SKID=1 register).
  - out_valid = 0 and load_use = 0.
- Reset asserted mid-stream discards every held entry with no flush_cnt increment.
- Latency: accept at edge N gives out_valid from edge N to the next edge; there are no combinational in-to-out paths.
- Throughput is 1 entry/cycle with out_ready held high, in both SKID modes.
- SKID=1: out_ready low for k cycles absorbs at most 2 entries. in_ready falls at the edge that fills S and rises at the edge after the first pop.
- SKID=1 has no combinational path from out_ready to in_ready. SKID=0 has exactly that one path.

## Test plan
- Reset, then a stream of payloads 1..8 with out_ready=1 -> out_data is 1..8 on consecutive cycles, in_ready stays 1, and each entry has 1-cycle latency.
- SKID=1: payloads A,B,C offered while out_ready=0 -> H=A, S=B, in_ready=0 while C is held. Then out_ready=1 -> A, B, C pop in order with no gap or duplicate.
- flush while H=A and S=B hold valid, with D offered -> next cycle out_valid=0, in_ready=1, D lost, flush_cnt=1. A second flush while empty leaves flush_cnt=1.
- Load hazard: H holds a load with rd=5, chk_rs2=5, chk_rs2_en=1 -> load_use=1. Change rd to 0, or is_load to 0, or chk_rs2_en to 0 -> load_use=0. Put the load in S instead -> load_use=1.
- rdy=0 for 3 cycles mid-stream with in_valid=1 and out_ready=1 -> no accept or pop, in_ready and out_valid are 0, and the stream resumes unchanged when rdy returns to 1.
- SKID=0: out_ready=0 with H full -> in_ready=0 in the same cycle. Raising out_ready with in_valid=1 -> pop and accept happen at the same edge.

Source files
------------

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register: valid/ready handshake, optional two-entry
// skid buffer, flush, global enable and load-use hazard detection over held entries.
module id_ex_pipe #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned RA_W   = 5,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_rd_en,
    input  logic              in_is_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RA_W-1:0]   out_rd,
    output logic              out_rd_en,
    input  logic [RA_W-1:0]   chk_rs1,
    input  logic [RA_W-1:0]   chk_rs2,
    input  logic              chk_rs1_en,
    input  logic              chk_rs2_en,
    output logic              load_use,
    output logic [15:0]       flush_cnt
);

    logic              h_valid, h_rd_en, h_is_load;
    logic [DATA_W-1:0] h_data;
    logic [RA_W-1:0]   h_rd;
    logic              s_valid, s_rd_en, s_is_load;
    logic [DATA_W-1:0] s_data;
    logic [RA_W-1:0]   s_rd;
    logic              in_ready_q;
    logic [15:0]       flush_cnt_q;
    logic              accept, pop;

    // Skid mode registers in_ready; single-entry mode lets out_ready through.
    always_comb begin
        if (SKID) in_ready = rdy & in_ready_q;
        else      in_ready = rdy & (~h_valid | out_ready);
    end

    assign out_valid = h_valid & rdy;
    assign out_data  = h_data;
    assign out_rd    = h_rd;
    assign out_rd_en = h_rd_en;
    assign flush_cnt = flush_cnt_q;
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    function automatic logic hazard(input logic v, input logic ld, input logic en,
                                    input logic [RA_W-1:0] rd);
        return v & ld & en & (rd != '0) &
               ((chk_rs1_en & (chk_rs1 == rd)) | (chk_rs2_en & (chk_rs2 == rd)));
    endfunction

    assign load_use = hazard(h_valid, h_is_load, h_rd_en, h_rd) |
                      hazard(s_valid, s_is_load, s_rd_en, s_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid     <= 1'b0;
            h_data      <= '0;
            h_rd        <= '0;
            h_rd_en     <= 1'b0;
            h_is_load   <= 1'b0;
            s_valid     <= 1'b0;
            s_data      <= '0;
            s_rd        <= '0;
            s_rd_en     <= 1'b0;
            s_is_load   <= 1'b0;
            in_ready_q  <= 1'b1;
            flush_cnt_q <= '0;
        end else if (rdy) begin
            if (flush) begin
                h_valid    <= 1'b0;
                s_valid    <= 1'b0;
                in_ready_q <= 1'b1;
                if ((h_valid | s_valid) && (flush_cnt_q != 16'hFFFF))
                    flush_cnt_q <= flush_cnt_q + 16'd1;
            end else if (SKID) begin
                if (!h_valid || (pop && !s_valid)) begin
                    h_valid    <= accept;
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        h_data    <= in_data;
                        h_rd      <= in_rd;
                        h_rd_en   <= in_rd_en;
                        h_is_load <= in_is_load;
                    end
                end else if (pop) begin
                    // Head drains, skid entry moves forward; in_ready was low so no accept.
                    h_valid    <= 1'b1;
                    h_data     <= s_data;
                    h_rd       <= s_rd;
                    h_rd_en    <= s_rd_en;
                    h_is_load  <= s_is_load;
                    s_valid    <= 1'b0;
                    in_ready_q <= 1'b1;
                end else if (accept) begin
                    s_valid    <= 1'b1;
                    s_data     <= in_data;
                    s_rd       <= in_rd;
                    s_rd_en    <= in_rd_en;
                    s_is_load  <= in_is_load;
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= ~s_valid;
                end
            end else begin
                if (accept) begin
                    h_valid   <= 1'b1;
                    h_data    <= in_data;
                    h_rd      <= in_rd;
                    h_rd_en   <= in_rd_en;
                    h_is_load <= in_is_load;
                end else if (pop) begin
                    h_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed vector table and hand sequences, then random
// traffic against queue-based models of the skid (SKID=1) and single-entry (SKID=0) variants.
module tb_id_ex_pipe;

    logic         clk = 1'b0;
    logic         rst, rdy, flush, in_valid, in_rd_en, in_is_load, out_ready;
    logic [127:0] in_data;
    logic [4:0]   in_rd, chk_rs1, chk_rs2;
    logic         chk_rs1_en, chk_rs2_en;

    logic         ir1, ov1, orde1, lu1, ir0, ov0, orde0, lu0;
    logic [127:0] od1, od0;
    logic [4:0]   ord1, ord0;
    logic [15:0]  fc1, fc0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.DATA_W(128), .RA_W(5), .SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_rd(in_rd),
        .in_rd_en(in_rd_en), .in_is_load(in_is_load),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_rd(ord1),
        .out_rd_en(orde1), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .chk_rs1_en(chk_rs1_en), .chk_rs2_en(chk_rs2_en), .load_use(lu1),
        .flush_cnt(fc1));

    id_ex_pipe #(.DATA_W(128), .RA_W(5), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_rd(in_rd),
        .in_rd_en(in_rd_en), .in_is_load(in_is_load),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_rd(ord0),
        .out_rd_en(orde0), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .chk_rs1_en(chk_rs1_en), .chk_rs2_en(chk_rs2_en), .load_use(lu0),
        .flush_cnt(fc0));

    typedef struct packed {
        logic        rst, rdy, flush, iv;
        logic [7:0]  d;
        logic        ordy, chk, e_ir, e_ov;
        logic [7:0]  e_d;
        logic [15:0] e_fc;
    } vec_t;

    typedef struct packed {
        logic [127:0] d;
        logic [4:0]   rd;
        logic         rd_en, ld;
    } ent_t;

    vec_t tbl[$];
    ent_t q1[$], q0[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic fl, input logic iv, input logic [7:0] d,
                                input logic ordy, input logic c, input logic eir, input logic eov,
                                input logic [7:0] ed, input logic [15:0] efc);
        vec_t v;
        v.rst = r; v.rdy = 1'b1; v.flush = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.chk = c; v.e_ir = eir; v.e_ov = eov; v.e_d = ed; v.e_fc = efc;
        return v;
    endfunction

    function automatic logic lu_q(input ent_t q[$]);
        logic r = 1'b0;
        foreach (q[i])
            if (q[i].ld && q[i].rd_en && q[i].rd != 5'd0 &&
                ((chk_rs1_en && chk_rs1 == q[i].rd) || (chk_rs2_en && chk_rs2 == q[i].rd)))
                r = 1'b1;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic [4:0] rd,
                         input logic rd_en, input logic ld);
        in_valid = iv; in_data = {120'd0, d}; in_rd = rd; in_rd_en = rd_en; in_is_load = ld;
    endtask

    logic        m_ir1, e_ir1, e_ir0;
    logic [15:0] m_fc1, m_fc0;

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'h0, 5'd0, 1'b0, 1'b0);
        chk_rs1 = '0; chk_rs2 = '0; chk_rs1_en = 1'b0; chk_rs2_en = 1'b0;
        @(posedge clk); #1;

        //            rst fl iv  d      ordy chk ir ov  e_d    fc
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(0, 0, 1, 8'(i), 1, 1, 1, (i > 1), 8'(i - 1), 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h08, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 1, 8'h0A, 0, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 1, 8'h0B, 0, 1, 1, 1, 8'h0A, 0));
        tbl.push_back(mk(0, 0, 1, 8'h0C, 0, 1, 0, 1, 8'h0A, 0));
        tbl.push_back(mk(0, 0, 1, 8'h0C, 1, 1, 0, 1, 8'h0A, 0));
        tbl.push_back(mk(0, 0, 1, 8'h0C, 1, 1, 1, 1, 8'h0B, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h0C, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 1, 8'h1A, 0, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 1, 8'h1B, 0, 1, 1, 1, 8'h1A, 0));
        tbl.push_back(mk(0, 1, 1, 8'h1D, 0, 1, 0, 1, 8'h1A, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 1));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; rdy = tbl[i].rdy; flush = tbl[i].flush; out_ready = tbl[i].ordy;
            drive(tbl[i].iv, tbl[i].d, 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d in_ready", i), {127'd0, ir1}, {127'd0, tbl[i].e_ir});
                chk($sformatf("tbl%0d out_valid", i), {127'd0, ov1}, {127'd0, tbl[i].e_ov});
                if (tbl[i].e_ov)
                    chk($sformatf("tbl%0d out_data", i), od1, {120'd0, tbl[i].e_d});
                chk($sformatf("tbl%0d flush_cnt", i), {112'd0, fc1}, {112'd0, tbl[i].e_fc});
                if (i == 1) chk("reset load_use", {127'd0, lu1}, 128'd0);
            end
            cyc();
        end

        // Load-use hazard, head entry
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 8'h55, 5'd5, 1'b1, 1'b1); cyc();
        drive(1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        chk_rs2 = 5'd5; chk_rs2_en = 1'b1;
        @(negedge clk); chk("hz head", {127'd0, lu1}, 128'd1); cyc();
        rdy = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("hz rdy0", {127'd0, lu1}, 128'd1);
        chk("hz rdy0 ov", {127'd0, ov1}, 128'd0);
        cyc();
        rdy = 1'b1; flush = 1'b0; chk_rs2_en = 1'b0;
        @(negedge clk); chk("hz en0", {127'd0, lu1}, 128'd0); cyc();
        chk_rs2_en = 1'b1; flush = 1'b1; cyc(); flush = 1'b0;
        drive(1'b1, 8'h56, 5'd0, 1'b1, 1'b1); cyc();
        drive(1'b0, 8'h00, 5'd0, 1'b0, 1'b0); chk_rs2 = 5'd0;
        @(negedge clk); chk("hz rd0", {127'd0, lu1}, 128'd0); cyc();
        flush = 1'b1; cyc(); flush = 1'b0;
        drive(1'b1, 8'h57, 5'd5, 1'b1, 1'b0); cyc();
        drive(1'b0, 8'h00, 5'd0, 1'b0, 1'b0); chk_rs2 = 5'd5;
        @(negedge clk); chk("hz notload", {127'd0, lu1}, 128'd0); cyc();
        flush = 1'b1; cyc(); flush = 1'b0;
        drive(1'b1, 8'h60, 5'd7, 1'b1, 1'b0); cyc();
        drive(1'b1, 8'h61, 5'd5, 1'b1, 1'b1); cyc();
        drive(1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("hz skid", {127'd0, lu1}, 128'd1);
        chk("hz skid head", od1, 128'h60);
        chk("hz skid ir", {127'd0, ir1}, 128'd0);
        chk("hz flush_cnt", {112'd0, fc1}, 128'd4);
        cyc();
        flush = 1'b1; cyc(); flush = 1'b0;
        chk_rs2_en = 1'b0; chk_rs2 = 5'd0;

        // rdy=0 freeze mid-stream
        out_ready = 1'b1;
        drive(1'b1, 8'h31, 5'd0, 1'b0, 1'b0); cyc();
        drive(1'b1, 8'h32, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("frz pre od1", od1, 128'h31); chk("frz pre od0", od0, 128'h31);
        cyc();
        rdy = 1'b0; drive(1'b1, 8'h33, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("frz ir1", {127'd0, ir1}, 128'd0); chk("frz ir0", {127'd0, ir0}, 128'd0);
            chk("frz ov1", {127'd0, ov1}, 128'd0); chk("frz ov0", {127'd0, ov0}, 128'd0);
            chk("frz od1", od1, 128'h32); chk("frz od0", od0, 128'h32);
            cyc();
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("res ov1", {127'd0, ov1}, 128'd1); chk("res od1", od1, 128'h32);
        chk("res ir1", {127'd0, ir1}, 128'd1); chk("res ir0", {127'd0, ir0}, 128'd1);
        cyc();
        drive(1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        @(negedge clk); chk("res od1b", od1, 128'h33); chk("res od0b", od0, 128'h33); cyc();
        @(negedge clk); chk("res empty1", {127'd0, ov1}, 128'd0); chk("res empty0", {127'd0, ov0}, 128'd0);
        cyc();

        // Single-entry variant: combinational out_ready -> in_ready
        out_ready = 1'b0;
        drive(1'b1, 8'h41, 5'd0, 1'b0, 1'b0);
        @(negedge clk); chk("s0 ir empty", {127'd0, ir0}, 128'd1); cyc();
        drive(1'b1, 8'h42, 5'd0, 1'b0, 1'b0);
        @(negedge clk); chk("s0 ir full", {127'd0, ir0}, 128'd0); chk("s0 od", od0, 128'h41); cyc();
        out_ready = 1'b1; drive(1'b1, 8'h43, 5'd0, 1'b0, 1'b0);
        @(negedge clk); chk("s0 ir pop", {127'd0, ir0}, 128'd1); cyc();
        out_ready = 1'b0; drive(1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
        @(negedge clk); chk("s0 ov", {127'd0, ov0}, 128'd1); chk("s0 od next", od0, 128'h43); cyc();

        // Random traffic against models
        rst = 1'b1; cyc(); rst = 1'b0;
        q1.delete(); q0.delete(); m_ir1 = 1'b1; m_fc1 = '0; m_fc0 = '0;
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            rdy        = ($urandom_range(0, 99) < 85);
            flush      = ($urandom_range(0, 15) == 0);
            out_ready  = ($urandom_range(0, 9) < 6);
            in_valid   = ($urandom_range(0, 9) < 7);
            in_data    = {$urandom, $urandom, $urandom, $urandom};
            in_rd      = 5'($urandom_range(0, 3));
            in_rd_en   = 1'($urandom);
            in_is_load = 1'($urandom);
            chk_rs1    = 5'($urandom_range(0, 3));
            chk_rs2    = 5'($urandom_range(0, 3));
            chk_rs1_en = 1'($urandom);
            chk_rs2_en = 1'($urandom);
            @(negedge clk);
            e_ir1 = rdy & m_ir1;
            e_ir0 = rdy & ((q0.size() == 0) | out_ready);
            chk("rnd ir1", {127'd0, ir1}, {127'd0, e_ir1});
            chk("rnd ir0", {127'd0, ir0}, {127'd0, e_ir0});
            chk("rnd ov1", {127'd0, ov1}, {127'd0, rdy & (q1.size() != 0)});
            chk("rnd ov0", {127'd0, ov0}, {127'd0, rdy & (q0.size() != 0)});
            chk("rnd lu1", {127'd0, lu1}, {127'd0, lu_q(q1)});
            chk("rnd lu0", {127'd0, lu0}, {127'd0, lu_q(q0)});
            chk("rnd fc1", {112'd0, fc1}, {112'd0, m_fc1});
            chk("rnd fc0", {112'd0, fc0}, {112'd0, m_fc0});
            if (q1.size() != 0) begin
                chk("rnd od1", od1, q1[0].d);
                chk("rnd ord1", {123'd0, ord1, orde1}, {123'd0, q1[0].rd, q1[0].rd_en});
            end
            if (q0.size() != 0) begin
                chk("rnd od0", od0, q0[0].d);
                chk("rnd ord0", {123'd0, ord0, orde0}, {123'd0, q0[0].rd, q0[0].rd_en});
            end
            @(posedge clk);
            if (rst) begin
                q1.delete(); q0.delete(); m_ir1 = 1'b1; m_fc1 = '0; m_fc0 = '0;
            end else if (rdy) begin
                if (flush) begin
                    if (q1.size() != 0 && m_fc1 != 16'hFFFF) m_fc1++;
                    if (q0.size() != 0 && m_fc0 != 16'hFFFF) m_fc0++;
                    q1.delete(); q0.delete(); m_ir1 = 1'b1;
                end else begin
                    if (q1.size() != 0 && out_ready) void'(q1.pop_front());
                    if (in_valid && e_ir1) q1.push_back({in_data, in_rd, in_rd_en, in_is_load});
                    m_ir1 = (q1.size() < 2);
                    if (q0.size() != 0 && out_ready) void'(q0.pop_front());
                    if (in_valid && e_ir0) q0.push_back({in_data, in_rd, in_rd_en, in_is_load});
                    if (q1.size() > 2 || q0.size() > 1) begin
                        n_err++;
                        $display("FAIL model overflow: q1 %0d q0 %0d", q1.size(), q0.size());
                    end
                end
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
